// File: rtl/regm_ctrl_pkg.sv
// Shared sizes and arbiter state encoding for the register-file write-port controller.
package regm_ctrl_pkg;
    localparam int NB_REGS    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REQ_EXEC   = 0;
    localparam int REQ_LSU    = 1;

    typedef enum logic {
        PRIO_LSU  = 1'b0,
        PRIO_EXEC = 1'b1
    } arb_state_t;
endpackage

// File: rtl/regm_scoreboard.sv
// Pending-write mask for the register file with reserve/clear/flush and
// combinational read-after-write hazard lookup for the two decode sources.
module regm_scoreboard
    import regm_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  reserve_i,
    input  logic [REG_ADDR_W-1:0] reserve_addr_i,
    input  logic                  flush_i,
    input  logic                  clr_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic                  hazard_o
);

    logic [NB_REGS-1:0] r_pending;
    logic [NB_REGS-1:0] w_pending_next;

    // x0 is never written, so it can never be pending.
    assign w_pending_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NB_REGS; gi++) begin : g_bit
            logic w_set;
            logic w_clr;
            assign w_set = reserve_i && (reserve_addr_i == REG_ADDR_W'(gi));
            assign w_clr = flush_i || (clr_i && (clr_addr_i == REG_ADDR_W'(gi)));
            // A reservation overrides both a commit and a flush in the same cycle.
            assign w_pending_next[gi] = w_set || (r_pending[gi] && !w_clr);
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign hazard_o = r_pending[raddr1_i] | r_pending[raddr2_i];

endmodule

// File: rtl/regm_ctrl.sv
// Shares the register-file write port between EXEC and LSU writebacks with a
// round-robin conflict arbiter, and tracks outstanding writes for hazard checks.
module regm_ctrl
    import regm_ctrl_pkg::*;
#(
    parameter int NB_REQ = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  exec_valid_i,
    output logic                  exec_ready_o,
    input  logic [REG_ADDR_W-1:0] exec_addr_i,
    input  logic [DATA_W-1:0]     exec_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0]     lsu_data_i,
    input  logic                  reserve_i,
    input  logic [REG_ADDR_W-1:0] reserve_addr_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic                  hazard_o,
    output logic                  write_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0]     wdata_o
);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [NB_REQ-1:0]     w_valid;
    logic [NB_REQ-1:0]     w_grant;
    logic [REG_ADDR_W-1:0] w_addr [NB_REQ];
    logic [DATA_W-1:0]     w_data [NB_REQ];
    logic                  w_any_grant;
    logic [REG_ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  r_write;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]     r_wdata;

    assign w_valid[REQ_EXEC] = exec_valid_i;
    assign w_valid[REQ_LSU]  = lsu_valid_i;
    assign w_addr[REQ_EXEC]  = exec_addr_i;
    assign w_addr[REQ_LSU]   = lsu_addr_i;
    assign w_data[REQ_EXEC]  = exec_data_i;
    assign w_data[REQ_LSU]   = lsu_data_i;

    // Arbiter: a lone request always wins; on conflict the state picks the winner.
    always_comb begin
        w_grant      = '0;
        w_state_next = r_state;
        if (w_valid[REQ_EXEC] && w_valid[REQ_LSU]) begin
            if (r_state == PRIO_LSU) begin
                w_grant[REQ_LSU] = 1'b1;
            end else begin
                w_grant[REQ_EXEC] = 1'b1;
            end
        end else begin
            w_grant = w_valid;
        end
        if (w_grant[REQ_LSU]) begin
            w_state_next = PRIO_EXEC;
        end else if (w_grant[REQ_EXEC]) begin
            w_state_next = PRIO_LSU;
        end
    end

    assign exec_ready_o = w_grant[REQ_EXEC];
    assign lsu_ready_o  = w_grant[REQ_LSU];
    assign w_any_grant  = |w_grant;
    assign w_sel_addr   = w_grant[REQ_LSU] ? w_addr[REQ_LSU] : w_addr[REQ_EXEC];
    assign w_sel_data   = w_grant[REQ_LSU] ? w_data[REQ_LSU] : w_data[REQ_EXEC];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= PRIO_LSU;
            r_write <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            // Writes to x0 complete the handshake but never reach the register file.
            r_write <= w_any_grant && (w_sel_addr != '0);
            if (w_any_grant) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    assign write_o = r_write;
    assign waddr_o = r_waddr;
    assign wdata_o = r_wdata;

    regm_scoreboard u_scoreboard (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reserve_i      (reserve_i),
        .reserve_addr_i (reserve_addr_i),
        .flush_i        (flush_i),
        .clr_i          (r_write),
        .clr_addr_i     (r_waddr),
        .raddr1_i       (raddr1_i),
        .raddr2_i       (raddr2_i),
        .hazard_o       (hazard_o)
    );

endmodule

// File: doc/regm_ctrl.md
Name: regm_ctrl

Overview:
Write-port arbiter and hazard scoreboard for the 32x32 register file (2 async read ports, 1 sync write port, x0 never written).
Shares the single write port between two writeback requesters: execute (EXEC, index 0) and load/store (LSU, index 1).
Tracks registers with an outstanding write and flags read-after-write hazards to the decode/issue stage.
Sits between the pipeline writeback sources and regm; drives regm write_i/waddr_i/wdata_i directly.

Parameters:
NB_REQ, 2, number of writeback requesters (fixed; not a generic N-way arbiter).

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
exec_valid_i  in  1  EXEC writeback request valid
exec_ready_o  out  1  EXEC request accepted this cycle
exec_addr_i  in  5  EXEC destination register
exec_data_i  in  32  EXEC result
lsu_valid_i  in  1  LSU writeback request valid
lsu_ready_o  out  1  LSU request accepted this cycle
lsu_addr_i  in  5  LSU destination register
lsu_data_i  in  32  LSU load data
reserve_i  in  1  issue stage marks a destination pending
reserve_addr_i  in  5  register to mark pending
flush_i  in  1  pipeline flush, clears pending mask
raddr1_i  in  5  decode source register 1
raddr2_i  in  5  decode source register 2
hazard_o  out  1  a source register has a pending write
write_o  out  1  to regm write_i
waddr_o  out  5  to regm waddr_i
wdata_o  out  32  to regm wdata_i

Behaviour:
- Reset (async, immediate): write_o=0, waddr_o=0, wdata_o=0, pending mask=0, arbiter state=PRIO_LSU. ready outputs are combinational; they read 0 when no valid.
- Handshake: transfer occurs when valid_i & ready_o in the same cycle. Requester holds addr/data stable while valid and not ready.
- Port is free every cycle, so exactly one request is granted whenever at least one is valid.
- Single valid: granted immediately.
- Both valid: grant follows the arbiter FSM.
- FSM states PRIO_LSU and PRIO_EXEC. PRIO_LSU grants LSU on conflict, then moves to PRIO_EXEC. PRIO_EXEC grants EXEC on conflict, then moves to PRIO_LSU.
- On a non-conflict grant, the state moves to favour the requester not granted.
- No grant leaves the state unchanged.
- Latency: transfer at cycle N; write_o=1 with registered addr/data in cycle N+1; regm updates at the end of N+1. write_o=0 in any cycle following no transfer.
- Address 0: handshake completes normally; write_o stays 0 in N+1.
- Pending mask (32 bits, bit 0 hard-wired 0): reserve_i sets bit reserve_addr_i at the next edge.
- The bit for waddr_o clears at the edge ending a cycle with write_o=1, the same edge regm commits. From N+2, hazard_o for that register is 0 and regm returns the new data.
- Same register reserved and cleared in the same cycle: reserve wins, bit stays 1.
- flush_i clears all bits at the next edge. reserve_i in the same cycle as flush_i still sets its bit.
- flush_i does not cancel a granted write or the registered write_o.
- hazard_o = pending[raddr1_i] | pending[raddr2_i], combinational; always 0 for address 0.
- Reserving an already-pending register keeps it at 1. Single-bit tracking is sufficient because writebacks are in order per destination.
- Reset mid-transfer: the registered write is dropped (write_o=0 immediately) and the mask is cleared.

Decomposition:
- Package regm_ctrl_pkg holds: NB_REGS=32, REG_ADDR_W=5, DATA_W=32, and typedef enum arb_state_t {PRIO_LSU, PRIO_EXEC}.
- Sub-module regm_scoreboard holds the pending mask, reserve/clear/flush logic, and hazard lookup.
- The arbiter, FSM and output register stay in regm_ctrl.

Test Plan:
- Reset, then exec_valid=1, addr=5, data=0xDEADBEEF -> exec_ready=1 at N; write_o=1, waddr=5, wdata=0xDEADBEEF at N+1; write_o=0 at N+2.
- Both valid every cycle for 4 cycles (EXEC addr 1, LSU addr 2) -> grants LSU, EXEC, LSU, EXEC; each loser holds its request; write_o sequence waddr 2,1,2,1.
- reserve addr 7, then raddr1=7 -> hazard_o=1 until the writeback of 7 commits; hazard_o=0 from N+2; with raddr1=0 hazard_o is always 0.
- Write request to addr 0 with data 0x1234 -> ready=1, write_o stays 0, mask unchanged.
- reserve addr 9 in the same cycle write_o=1 with waddr 9 -> bit 9 remains set, hazard_o=1 for raddr2=9.
- Reserve 3 and 4, then flush_i while reserving 6 -> afterwards only bit 6 is set; assert rst_i mid-transfer -> write_o drops to 0 the same cycle.
